// File: rtl/bus_sequencer.sv
// Shares one system bus between a slow CPU (upper half of each CPU cycle) and
// round-robin auxiliary requesters (3-cycle slots in the lower half).
// Optional: define BUS_SEQ_WRITE_PROTECT_EN to suppress CPU writes to ROM.
module bus_sequencer #(
   parameter int NUM_REQ    = 3,
   parameter int ADDR_WIDTH = 17,
   parameter int DATA_WIDTH = 8,
   parameter int CPU_DIV    = 16
) (
   input  logic                          clk_16_i,
   input  logic                          reset_ni,
   output logic                          clk_cpu_o,
   input  logic                          cpu_valid_i,
   input  logic                          cpu_rw_ni,
   input  logic                          cpu_readonly_i,
   output logic                          cpu_en_o,
   input  logic [NUM_REQ-1:0]            req_valid_i,
   input  logic [NUM_REQ-1:0]            req_rw_ni,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
   output logic [NUM_REQ-1:0]            req_ready_o,
   output logic [DATA_WIDTH-1:0]         rd_data_o,
   output logic [$clog2(NUM_REQ)-1:0]    grant_o,
   input  logic [DATA_WIDTH-1:0]         bus_data_i,
   output logic [ADDR_WIDTH-1:0]         bus_addr_o,
   output logic [DATA_WIDTH-1:0]         bus_data_o,
   output logic                          bus_addr_oe_o,
   output logic                          bus_data_oe_o,
   output logic                          bus_rw_no,
   output logic                          ram_oe_no,
   output logic                          ram_we_no
);

   localparam int GW       = $clog2(NUM_REQ);
   localparam int PW       = $clog2(CPU_DIV);
   localparam int HALF     = CPU_DIV / 2;
   localparam int SLOTS    = (HALF - 1) / 3;
   localparam int SLOT_END = 3 * SLOTS;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SETUP  = 2'd1;
   localparam logic [1:0] S_STROBE = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   logic [PW-1:0]         phase, phase_next;
   logic [1:0]            state;
   logic                  clk_cpu, cpu_en;
   logic [GW-1:0]         grant, nxt_grant;
   logic                  found, slot_start, launch, aux_on;
   logic [NUM_REQ-1:0]    grant_oh, eligible;
   logic [ADDR_WIDTH-1:0] addr_q, sel_addr;
   logic [DATA_WIDTH-1:0] wdata_q, sel_data, rd_q;
   logic                  rw_q, sel_rw;
   logic                  cpu_we_win, cpu_wp;

   assign phase_next = (phase == PW'(CPU_DIV - 1)) ? '0 : phase + 1'b1;
   assign slot_start = (int'(phase_next) < SLOT_END) && (int'(phase_next) % 3 == 0);

   always_comb begin
      grant_oh = '0;
      for (int k = 0; k < NUM_REQ; k++)
         grant_oh[k] = (int'(grant) == k);
   end

   // The grantee's valid is still high in its ready cycle; that is not a new request.
   assign eligible = req_valid_i & ~((state == S_DONE) ? grant_oh : '0);

   always_comb begin
      nxt_grant = grant;
      found     = 1'b0;
      for (int i = 1; i <= NUM_REQ; i++)
         for (int k = 0; k < NUM_REQ; k++)
            if (!found && eligible[k] && (k == (int'(grant) + i) % NUM_REQ)) begin
               nxt_grant = GW'(k);
               found     = 1'b1;
            end
   end

   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      sel_rw   = 1'b1;
      for (int k = 0; k < NUM_REQ; k++)
         if (int'(nxt_grant) == k) begin
            sel_addr = req_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
            sel_data = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            sel_rw   = req_rw_ni[k];
         end
   end

   // DONE may chain straight into the next slot's SETUP.
   assign launch = ((state == S_IDLE) || (state == S_DONE)) && slot_start && found;

   always_ff @(posedge clk_16_i or negedge reset_ni) begin
      if (!reset_ni) begin
         phase   <= '0;
         clk_cpu <= 1'b0;
         cpu_en  <= 1'b0;
      end else begin
         phase   <= phase_next;
         clk_cpu <= (phase_next >= PW'(HALF));
         if (phase == PW'(HALF - 1))
            cpu_en <= cpu_valid_i;
         else if (phase == PW'(CPU_DIV - 1))
            cpu_en <= 1'b0;
      end
   end

   always_ff @(posedge clk_16_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state   <= S_IDLE;
         grant   <= GW'(NUM_REQ - 1);
         addr_q  <= '0;
         wdata_q <= '0;
         rw_q    <= 1'b1;
         rd_q    <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE: state <= launch ? S_SETUP : S_IDLE;
            S_SETUP:        state <= S_STROBE;
            S_STROBE:       state <= S_DONE;
            default:        state <= S_IDLE;
         endcase
         if (launch) begin
            grant   <= nxt_grant;
            addr_q  <= sel_addr;
            wdata_q <= sel_data;
            rw_q    <= sel_rw;
         end
         if (state == S_STROBE && rw_q)
            rd_q <= bus_data_i;
      end
   end

`ifdef BUS_SEQ_WRITE_PROTECT_EN
   assign cpu_wp = cpu_readonly_i;
`else
   logic unused_readonly;
   assign unused_readonly = cpu_readonly_i;
   assign cpu_wp          = 1'b0;
`endif

   // CPU write strobe skips the first and last enabled phase for address/data setup and hold.
   assign cpu_we_win = (phase >= PW'(HALF + 1)) && (phase <= PW'(CPU_DIV - 2));
   assign aux_on     = (state != S_IDLE);

   assign ram_oe_no     = ~(((state == S_STROBE) && rw_q) || (cpu_en && cpu_rw_ni));
   assign ram_we_no     = ~(((state == S_STROBE) && !rw_q) ||
                            (cpu_en && !cpu_rw_ni && cpu_we_win && !cpu_wp));
   assign bus_addr_oe_o = aux_on;
   assign bus_data_oe_o = aux_on && !rw_q;
   assign bus_rw_no     = aux_on ? rw_q : 1'b1;
   assign bus_addr_o    = addr_q;
   assign bus_data_o    = wdata_q;
   assign rd_data_o     = rd_q;
   assign grant_o       = grant;
   assign clk_cpu_o     = clk_cpu;
   assign cpu_en_o      = cpu_en;
   assign req_ready_o   = (state == S_DONE) ? grant_oh : '0;

endmodule

// File: tb/tb_bus_sequencer.sv
// Directed bench for bus_sequencer: two per-cycle vector tables plus
// hand-written sequences for request drop, reset mid-access and CPU gating.
module tb_bus_sequencer;
   localparam int NR = 3, AW = 17, DW = 8, DIV = 16;

`ifdef BUS_SEQ_WRITE_PROTECT_EN
   localparam bit WP = 1'b1;
`else
   localparam bit WP = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            reset_ni;
   logic            clk_cpu_o, cpu_valid_i, cpu_rw_ni, cpu_readonly_i, cpu_en_o;
   logic [NR-1:0]   req_valid_i, req_rw_ni, req_ready_o;
   logic [NR*AW-1:0] req_addr_i;
   logic [NR*DW-1:0] req_data_i;
   logic [DW-1:0]   rd_data_o, bus_data_i, bus_data_o;
   logic [1:0]      grant_o;
   logic [AW-1:0]   bus_addr_o;
   logic            bus_addr_oe_o, bus_data_oe_o, bus_rw_no, ram_oe_no, ram_we_no;

   always #5 clk = ~clk;

   bus_sequencer #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CPU_DIV(DIV)) dut (
      .clk_16_i(clk), .reset_ni(reset_ni), .clk_cpu_o(clk_cpu_o),
      .cpu_valid_i(cpu_valid_i), .cpu_rw_ni(cpu_rw_ni), .cpu_readonly_i(cpu_readonly_i),
      .cpu_en_o(cpu_en_o), .req_valid_i(req_valid_i), .req_rw_ni(req_rw_ni),
      .req_addr_i(req_addr_i), .req_data_i(req_data_i), .req_ready_o(req_ready_o),
      .rd_data_o(rd_data_o), .grant_o(grant_o), .bus_data_i(bus_data_i),
      .bus_addr_o(bus_addr_o), .bus_data_o(bus_data_o), .bus_addr_oe_o(bus_addr_oe_o),
      .bus_data_oe_o(bus_data_oe_o), .bus_rw_no(bus_rw_no), .ram_oe_no(ram_oe_no),
      .ram_we_no(ram_we_no));

   typedef struct {
      logic       cpu_valid, cpu_rw_n, cpu_ro;
      logic [2:0] req_valid, req_rw_n;
      logic [7:0] bus_data;
      logic       clk_cpu, cpu_en, oe_n, we_n, addr_oe, data_oe, rw_n;
      logic [2:0] ready;
      logic [7:0] rd, wdata;
      logic [1:0] grant;
      logic [16:0] addr;
   } vec_t;

   vec_t va[32];
   vec_t vb[48];
   int vectors = 0;
   int errors  = 0;

   function automatic logic [16:0] addr_of(input int g);
      return (g == 0) ? 17'h08000 : (g == 1) ? 17'h10001 : 17'h1FFFF;
   endfunction

   function automatic logic [7:0] data_of(input int g);
      return (g == 0) ? 8'h11 : (g == 1) ? 8'h22 : 8'h33;
   endfunction

   function automatic vec_t idle_row(input int p);
      vec_t v;
      v.cpu_valid = 1'b0; v.cpu_rw_n = 1'b1; v.cpu_ro = 1'b0;
      v.req_valid = 3'b000; v.req_rw_n = 3'b111; v.bus_data = 8'h3C;
      v.clk_cpu = (p >= 8); v.cpu_en = 1'b0; v.oe_n = 1'b1; v.we_n = 1'b1;
      v.addr_oe = 1'b0; v.data_oe = 1'b0; v.rw_n = 1'b1; v.ready = 3'b000;
      v.rd = 8'h00; v.wdata = 8'h00; v.grant = 2'd2; v.addr = 17'h0;
      return v;
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @%0d: got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   task automatic apply(input vec_t v);
      cpu_valid_i = v.cpu_valid; cpu_rw_ni = v.cpu_rw_n; cpu_readonly_i = v.cpu_ro;
      req_valid_i = v.req_valid; req_rw_ni = v.req_rw_n; bus_data_i = v.bus_data;
   endtask

   task automatic check_row(input string tag, input int i, input vec_t v);
      chk({tag, ".clk_cpu"}, i, 32'(clk_cpu_o), 32'(v.clk_cpu));
      chk({tag, ".cpu_en"},  i, 32'(cpu_en_o),  32'(v.cpu_en));
      chk({tag, ".ram_oe_n"}, i, 32'(ram_oe_no), 32'(v.oe_n));
      chk({tag, ".ram_we_n"}, i, 32'(ram_we_no), 32'(v.we_n));
      chk({tag, ".addr_oe"}, i, 32'(bus_addr_oe_o), 32'(v.addr_oe));
      chk({tag, ".data_oe"}, i, 32'(bus_data_oe_o), 32'(v.data_oe));
      chk({tag, ".bus_rw_n"}, i, 32'(bus_rw_no), 32'(v.rw_n));
      chk({tag, ".ready"},   i, 32'(req_ready_o), 32'(v.ready));
      chk({tag, ".rd_data"}, i, 32'(rd_data_o), 32'(v.rd));
      chk({tag, ".wdata"},   i, 32'(bus_data_o), 32'(v.wdata));
      chk({tag, ".grant"},   i, 32'(grant_o), 32'(v.grant));
      chk({tag, ".addr"},    i, 32'(bus_addr_o), 32'(v.addr));
   endtask

   // Leaves the bench just after a rising edge, in the phase-0 cycle.
   task automatic reset_dut();
      apply(idle_row(0));
      reset_ni = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_row("reset", 0, idle_row(0));
      @(posedge clk); #1;
      reset_ni = 1'b1;
   endtask

   task automatic next_cycle();
      @(posedge clk); #1;
   endtask

   initial begin
      req_addr_i = {17'h1FFFF, 17'h10001, 17'h08000};
      req_data_i = {8'h33, 8'h22, 8'h11};

      // Table A: CPU reads in frame 0, aux read at frame 1 phase 0, CPU write to ROM in frame 1.
      for (int i = 0; i < 32; i++) begin
         int p;
         p = i % 16;
         va[i] = idle_row(p);
         va[i].cpu_valid = 1'b1;
         if (p >= 8) begin
            va[i].cpu_en = 1'b1;
            if (i >= 24) begin
               va[i].cpu_rw_n = 1'b0;
               va[i].cpu_ro   = 1'b1;
            end else
               va[i].oe_n = 1'b0;
         end
         if (i >= 25 && i <= 30) va[i].we_n = WP;
         if (i >= 15 && i <= 18) va[i].req_valid = 3'b001;
         if (i >= 16) begin
            va[i].grant = 2'd0; va[i].addr = 17'h08000; va[i].wdata = 8'h11;
         end
         if (i >= 16 && i <= 18) va[i].addr_oe = 1'b1;
         if (i == 17) begin va[i].bus_data = 8'hA5; va[i].oe_n = 1'b0; end
         if (i == 18) va[i].ready = 3'b001;
         if (i >= 18) va[i].rd = 8'hA5;
      end

      // Table B: all three requesters held valid, requester 1 writes, CPU idle.
      for (int i = 0; i < 48; i++) begin
         int p, g;
         p = i % 16;
         vb[i] = idle_row(p);
         vb[i].bus_data = 8'(8'h40 + i);
         vb[i].req_rw_n = 3'b101;
         if (i >= 15) vb[i].req_valid = 3'b111;
         g = 2;
         if (i >= 16 && i <= 18) g = 0;
         if (i >= 19 && i <= 31) g = 1;
         if (i >= 32 && i <= 34) g = 2;
         if (i >= 35) g = 0;
         vb[i].grant = 2'(g);
         if (i >= 16) begin vb[i].addr = addr_of(g); vb[i].wdata = data_of(g); end
         if ((i >= 16 && i <= 21) || (i >= 32 && i <= 37)) vb[i].addr_oe = 1'b1;
         if (i == 17 || i == 33 || i == 36) vb[i].oe_n = 1'b0;
         if (i == 20) vb[i].we_n = 1'b0;
         if (i >= 19 && i <= 21) begin vb[i].data_oe = 1'b1; vb[i].rw_n = 1'b0; end
         if (i == 18 || i == 37) vb[i].ready = 3'b001;
         if (i == 21) vb[i].ready = 3'b010;
         if (i == 34) vb[i].ready = 3'b100;
         if (i >= 18) vb[i].rd = 8'h51;
         if (i >= 34) vb[i].rd = 8'h61;
         if (i >= 37) vb[i].rd = 8'h64;
      end

      reset_dut();
      for (int i = 0; i < 32; i++) begin
         apply(va[i]);
         @(negedge clk);
         check_row("tabA", i, va[i]);
         next_cycle();
      end

      reset_dut();
      for (int i = 0; i < 48; i++) begin
         apply(vb[i]);
         @(negedge clk);
         check_row("tabB", i, vb[i]);
         next_cycle();
      end

      // Write from requester 1, dropped during STROBE; CPU valid low only at phase 7.
      reset_dut();
      cpu_rw_ni = 1'b1;
      for (int p = 0; p < 16; p++) begin
         cpu_valid_i = (p != 7);
         if (p == 15) begin req_valid_i = 3'b010; req_rw_ni = 3'b101; end
         @(negedge clk);
         if (p == 8)  chk("gate.cpu_en", p, 32'(cpu_en_o), 32'd0);
         if (p == 12) chk("gate.ram_oe_n", p, 32'(ram_oe_no), 32'd1);
         next_cycle();
      end
      @(negedge clk);
      chk("drop.setup_addr_oe", 0, 32'(bus_addr_oe_o), 32'd1);
      chk("drop.setup_data_oe", 0, 32'(bus_data_oe_o), 32'd1);
      chk("drop.setup_rw_n", 0, 32'(bus_rw_no), 32'd0);
      chk("drop.grant", 0, 32'(grant_o), 32'd1);
      chk("drop.addr", 0, 32'(bus_addr_o), 32'h10001);
      chk("drop.wdata", 0, 32'(bus_data_o), 32'h22);
      chk("drop.setup_we_n", 0, 32'(ram_we_no), 32'd1);
      next_cycle();
      req_valid_i = 3'b000;
      @(negedge clk);
      chk("drop.strobe_we_n", 1, 32'(ram_we_no), 32'd0);
      chk("drop.strobe_oe_n", 1, 32'(ram_oe_no), 32'd1);
      next_cycle();
      @(negedge clk);
      chk("drop.done_ready", 2, 32'(req_ready_o), 32'b010);
      chk("drop.done_we_n", 2, 32'(ram_we_no), 32'd1);
      chk("drop.done_rd_data", 2, 32'(rd_data_o), 32'd0);
      next_cycle();
      @(negedge clk);
      chk("drop.after_ready", 3, 32'(req_ready_o), 32'd0);
      chk("drop.after_addr_oe", 3, 32'(bus_addr_oe_o), 32'd0);

      // Reset during STROBE of a read.
      reset_dut();
      for (int p = 0; p < 16; p++) begin
         if (p == 15) begin req_valid_i = 3'b001; req_rw_ni = 3'b111; end
         next_cycle();
      end
      @(negedge clk);
      chk("rst.setup_addr_oe", 0, 32'(bus_addr_oe_o), 32'd1);
      next_cycle();
      @(negedge clk);
      chk("rst.strobe_oe_n", 1, 32'(ram_oe_no), 32'd0);
      #2 reset_ni = 1'b0;
      #1;
      chk("rst.async_oe_n", 1, 32'(ram_oe_no), 32'd1);
      chk("rst.async_we_n", 1, 32'(ram_we_no), 32'd1);
      chk("rst.async_ready", 1, 32'(req_ready_o), 32'd0);
      chk("rst.async_addr_oe", 1, 32'(bus_addr_oe_o), 32'd0);
      req_valid_i = 3'b000;
      repeat (2) @(posedge clk);
      #1 reset_ni = 1'b1;
      for (int p = 0; p < 9; p++) begin
         @(negedge clk);
         chk("rst.no_ready", p, 32'(req_ready_o), 32'd0);
         if (p <= 2) chk("rst.no_resume", p, 32'(bus_addr_oe_o), 32'd0);
         if (p == 7) chk("rst.phase7_clk", p, 32'(clk_cpu_o), 32'd0);
         if (p == 8) chk("rst.phase8_clk", p, 32'(clk_cpu_o), 32'd1);
         next_cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule

// File: doc/bus_sequencer.md
BUS_SEQUENCER -- requirements
Module: bus_sequencer

Interface
REQ-001 Parameter: NUM_REQ, 3, number of auxiliary bus requesters (SPI, DMA, video fetch); SHALL be >= 2.
REQ-002 Parameter: ADDR_WIDTH, 17, system address width.
REQ-003 Parameter: DATA_WIDTH, 8, system data width.
REQ-004 Parameter: CPU_DIV, 16, clk_16_i cycles per CPU cycle; SHALL be even and >= 8.
REQ-005 Port: clk_16_i  in  1  sole clock; all state changes on rising edge.
REQ-006 Port: reset_ni  in  1  asynchronous, active-low reset.
REQ-007 Port: clk_cpu_o  out  1  CPU clock, low for phases 0..CPU_DIV/2-1, high for CPU_DIV/2..CPU_DIV-1.
REQ-008 Ports: cpu_valid_i  in  1  CPU permitted to run; cpu_rw_ni  in  1  0=CPU write; cpu_readonly_i  in  1  target is ROM.
REQ-009 Port: cpu_en_o  out  1  CPU owns the bus (BE).
REQ-010 Ports: req_valid_i / req_rw_ni  in  NUM_REQ; req_addr_i  in  NUM_REQ*ADDR_WIDTH; req_data_i  in  NUM_REQ*DATA_WIDTH; requester k occupies slice [k*W +: W].
REQ-011 Ports: req_ready_o  out  NUM_REQ  one-cycle completion pulse; rd_data_o  out  DATA_WIDTH  last read result; grant_o  out  $clog2(NUM_REQ)  current/last grantee.
REQ-012 Ports: bus_data_i  in  DATA_WIDTH; bus_addr_o  out  ADDR_WIDTH; bus_data_o  out  DATA_WIDTH; bus_addr_oe_o, bus_data_oe_o, bus_rw_no, ram_oe_no, ram_we_no  out  1.

Function
REQ-013 Phase counter SHALL count 0..CPU_DIV-1 and wrap to 0; clk_cpu_o SHALL be registered from the phase.
REQ-014 cpu_en_o SHALL be 1 for phases CPU_DIV/2..CPU_DIV-1 iff cpu_valid_i was 1 at phase CPU_DIV/2-1; otherwise 0 for the whole CPU cycle.
REQ-015 With cpu_en_o=1: ram_oe_no=0 when cpu_rw_ni=1; ram_we_no=0 when cpu_rw_ni=0 in phases CPU_DIV/2+1..CPU_DIV-2 only; bus_addr_oe_o=bus_data_oe_o=0.
REQ-016 Auxiliary slots SHALL start at phases 0,3,6,...; slot count S=floor((CPU_DIV/2-1)/3) (2 for CPU_DIV=16); phases after the last slot through CPU_DIV/2-1 are guard cycles.
REQ-017 Access FSM states: IDLE, SETUP, STROBE, DONE; each non-IDLE state lasts exactly one cycle.
REQ-018 On the edge entering a slot-start phase, if any req_valid_i=1 the FSM SHALL go IDLE->SETUP and latch grantee, addr, data, rw; else stay IDLE.
REQ-019 Grant: round-robin, first valid index strictly after the last grantee, wrapping; after reset the last grantee is NUM_REQ-1 (so index 0 wins first).
REQ-020 SETUP: bus_addr_oe_o=1, bus_rw_no=latched rw, bus_data_oe_o=1 for writes; strobes inactive.
REQ-021 STROBE: ram_oe_no=0 (read) or ram_we_no=0 (write); address/data/rw held.
REQ-022 DONE: strobes inactive, address/data still driven; read data captured from bus_data_i on the STROBE->DONE edge into rd_data_o; req_ready_o[grantee]=1 for exactly this cycle.
REQ-023 rd_data_o SHALL hold until the next read completion; writes SHALL not change it.
REQ-024 Request deasserted after latching SHALL not abort the access; ready still pulses.
REQ-025 Requester SHALL keep valid high until its ready; a requester still valid in the cycle after its ready is a new request.
REQ-026 Outside SETUP/STROBE/DONE and CPU window: bus_addr_oe_o=bus_data_oe_o=0, bus_rw_no=1, ram_oe_no=ram_we_no=1.

Reset
REQ-027 While reset_ni=0: phase=0, FSM=IDLE, clk_cpu_o=0, cpu_en_o=0, req_ready_o=0, rd_data_o=0, grant_o=NUM_REQ-1, bus_addr_o=bus_data_o=0, oe outputs 0, bus_rw_no=1, ram_oe_no=ram_we_no=1.
REQ-028 Reset asserted mid-access SHALL deassert all strobes immediately, with no ready pulse; after release the sequence restarts at phase 0.

Configuration
REQ-029 Macro BUS_SEQ_WRITE_PROTECT_EN defined: CPU writes with cpu_readonly_i=1 SHALL keep ram_we_no=1; auxiliary writes unaffected.
REQ-030 Macro undefined: cpu_readonly_i SHALL be ignored; all CPU writes strobe ram_we_no.

Verification (CPU_DIV=16, NUM_REQ=3)
REQ-031 Release reset, cpu_valid_i=1, no requests -> clk_cpu_o period 16 cycles, high phases 8..15; cpu_en_o high phases 8..15.
REQ-032 req_valid_i=3'b001 read, addr 17'h08000, bus_data_i=8'hA5 in STROBE -> SETUP phase 0, ram_oe_no low phase 1, req_ready_o[0] and rd_data_o=8'hA5 at phase 2.
REQ-033 req_valid_i=3'b111 held -> grants 0,1 in frame 1 (phases 0,3), 2,0 in frame 2; no slot in phases 6..7.
REQ-034 Write request deasserted during STROBE -> ram_we_no low one cycle, ready still pulses in DONE.
REQ-035 reset_ni low during STROBE -> ram_oe_no/ram_we_no high same cycle, no ready pulse, phase 0 after release.
REQ-036 CPU write, cpu_readonly_i=1 -> ram_we_no stays 1 with BUS_SEQ_WRITE_PROTECT_EN, low phases 9..14 without.
